// File: rtl/branch_resolve_unit.sv
// Branch resolve for the RV32I EX stage: funct3 decode, outcome, mispredict flush/redirect, 2-bit BHT, perf counters.
// Latency: prediction and resolve are combinational; BHT/counter updates land on the next rising edge.
// Backpressure: none; the pipeline qualifies flush/taken with its own valid/stall handling.
module branch_resolve_unit #(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_if_pc,
    output logic             o_if_pred_taken,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic [2:0]       i_ex_funct3,
    input  logic [31:0]      i_ex_pc,
    input  logic [31:0]      i_ex_target,
    input  logic             i_ex_pred_taken,
    output logic             o_ex_br_un,
    input  logic             i_ex_br_less,
    input  logic             i_ex_br_equal,
    output logic             o_ex_taken,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    localparam int DEPTH = 1 << INDEX_W;

    typedef struct packed {
        logic legal;
        logic signed_cmp;
        logic use_less;
        logic invert;
    } br_dec_t;

    br_dec_t              dec;
    logic                 br_v;
    logic                 cmp_hit;
    logic [31:0]          pc_plus4;
    logic [INDEX_W-1:0]   if_idx;
    logic [INDEX_W-1:0]   ex_idx;
    logic [1:0]           bht [DEPTH];
    logic [1:0]           bht_cur;
    logic [1:0]           bht_nxt;
    logic                 unused_pc_bits;

    // BNE/BGE(U) reuse the EQ/LT flag inverted; equality is mode-independent so only BLT/BGE pick signed.
    always_comb begin
        dec = '0;
        case (i_ex_funct3)
            3'b000:  dec = '{legal: 1'b1, signed_cmp: 1'b0, use_less: 1'b0, invert: 1'b0};
            3'b001:  dec = '{legal: 1'b1, signed_cmp: 1'b0, use_less: 1'b0, invert: 1'b1};
            3'b100:  dec = '{legal: 1'b1, signed_cmp: 1'b1, use_less: 1'b1, invert: 1'b0};
            3'b101:  dec = '{legal: 1'b1, signed_cmp: 1'b1, use_less: 1'b1, invert: 1'b1};
            3'b110:  dec = '{legal: 1'b1, signed_cmp: 1'b0, use_less: 1'b1, invert: 1'b0};
            3'b111:  dec = '{legal: 1'b1, signed_cmp: 1'b0, use_less: 1'b1, invert: 1'b1};
            default: dec = '0;
        endcase
    end

    assign o_ex_br_un = dec.signed_cmp;
    assign br_v       = i_ex_valid & i_ex_is_branch & dec.legal;
    assign cmp_hit    = dec.use_less ? i_ex_br_less : i_ex_br_equal;
    assign o_ex_taken = br_v & (cmp_hit ^ dec.invert);
    assign o_flush    = br_v & (o_ex_taken != i_ex_pred_taken);

    // A correctly predicted taken branch leaves fetch alone, so the target only escapes on a flush.
    assign pc_plus4      = i_ex_pc + 32'd4;
    assign o_redirect_pc = (o_flush & o_ex_taken) ? i_ex_target : pc_plus4;

    assign if_idx          = i_if_pc[INDEX_W+1:2];
    assign ex_idx          = i_ex_pc[INDEX_W+1:2];
    assign o_if_pred_taken = bht[if_idx][1];
    assign unused_pc_bits  = ^{i_if_pc[31:INDEX_W+2], i_if_pc[1:0]};

    always_comb begin
        bht_cur = bht[ex_idx];
        bht_nxt = bht_cur;
        if (o_ex_taken) begin
            if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'd1;
        end
    end

    // Same-index IF read sees the old entry because the write lands only on the edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
        end else if (br_v) begin
            bht[ex_idx] <= bht_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else begin
            if (br_v && (o_br_count != {CNT_W{1'b1}}))
                o_br_count <= o_br_count + 1'b1;
            if (o_flush && (o_mispred_count != {CNT_W{1'b1}}))
                o_mispred_count <= o_mispred_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scenarios plus randomized operand traffic against a behavioural branch/BHT model.
module tb_branch_resolve_unit;

    localparam int INDEX_W = 6;
    localparam int CNT_W   = 32;
    localparam int DEPTH   = 1 << INDEX_W;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [31:0]      i_if_pc;
    logic             o_if_pred_taken;
    logic             i_ex_valid;
    logic             i_ex_is_branch;
    logic [2:0]       i_ex_funct3;
    logic [31:0]      i_ex_pc;
    logic [31:0]      i_ex_target;
    logic             i_ex_pred_taken;
    logic             o_ex_br_un;
    logic             i_ex_br_less;
    logic             i_ex_br_equal;
    logic             o_ex_taken;
    logic             o_flush;
    logic [31:0]      o_redirect_pc;
    logic [CNT_W-1:0] o_br_count;
    logic [CNT_W-1:0] o_mispred_count;

    branch_resolve_unit #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_if_pc         (i_if_pc),
        .o_if_pred_taken (o_if_pred_taken),
        .i_ex_valid      (i_ex_valid),
        .i_ex_is_branch  (i_ex_is_branch),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_pc         (i_ex_pc),
        .i_ex_target     (i_ex_target),
        .i_ex_pred_taken (i_ex_pred_taken),
        .o_ex_br_un      (o_ex_br_un),
        .i_ex_br_less    (i_ex_br_less),
        .i_ex_br_equal   (i_ex_br_equal),
        .o_ex_taken      (o_ex_taken),
        .o_flush         (o_flush),
        .o_redirect_pc   (o_redirect_pc),
        .o_br_count      (o_br_count),
        .o_mispred_count (o_mispred_count)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bht_m [DEPTH];
    logic [31:0] brc_m;
    logic [31:0] mis_m;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic legal_of(input logic [2:0] f3);
        return (f3 != 3'd2) && (f3 != 3'd3);
    endfunction

    // Architectural branch semantics on the real operands.
    function automatic logic isa_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic pred_of(input logic [31:0] pc);
        return bht_m[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
        brc_m = 0;
        mis_m = 0;
    endtask

    task automatic model_clock(input logic bv, input logic [31:0] pc, input logic tk, input logic fl);
        if (bv) begin
            if (tk) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 3) ? 3 : bht_m[idx_of(pc)] + 1;
            else    bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 0) ? 0 : bht_m[idx_of(pc)] - 1;
            if (brc_m != 32'hFFFF_FFFF) brc_m = brc_m + 1;
        end
        if (fl && mis_m != 32'hFFFF_FFFF) mis_m = mis_m + 1;
    endtask

    task automatic drive(input logic v, input logic br, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred, input logic less, input logic eq);
        i_ex_valid      = v;
        i_ex_is_branch  = br;
        i_ex_funct3     = f3;
        i_ex_pc         = pc;
        i_ex_target     = tgt;
        i_ex_pred_taken = pred;
        i_ex_br_less    = less;
        i_ex_br_equal   = eq;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_if_pc = 32'h100;
        drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        model_reset();
        #12;
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        n_cmp++; if (o_if_pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred got %b want 0", o_if_pred_taken); end
        n_cmp++; if (o_br_count !== 32'd0) begin n_bad++; $display("FAIL reset_br_count got %0d want 0", o_br_count); end
        n_cmp++; if (o_mispred_count !== 32'd0) begin n_bad++; $display("FAIL reset_mis_count got %0d want 0", o_mispred_count); end
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", o_flush); end
        n_cmp++; if (o_redirect_pc !== 32'h4) begin n_bad++; $display("FAIL reset_redirect got %h want 00000004", o_redirect_pc); end
    endtask

    task automatic test_beq();
        @(negedge i_clk);
        i_if_pc = 32'h100;
        drive(1, 1, 3'd0, 32'h100, 32'h80, 0, 0, 1);
        #1;
        n_cmp++; if (o_ex_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken got %b want 1", o_ex_taken); end
        n_cmp++; if (o_flush !== 1'b1) begin n_bad++; $display("FAIL beq_flush got %b want 1", o_flush); end
        n_cmp++; if (o_redirect_pc !== 32'h80) begin n_bad++; $display("FAIL beq_redirect got %h want 00000080", o_redirect_pc); end
        n_cmp++; if (o_ex_br_un !== 1'b0) begin n_bad++; $display("FAIL beq_br_un got %b want 0", o_ex_br_un); end
        n_cmp++; if (o_if_pred_taken !== 1'b0) begin n_bad++; $display("FAIL beq_pred_before got %b want 0", o_if_pred_taken); end
        @(posedge i_clk);
        model_clock(1, 32'h100, 1, 1);
        @(negedge i_clk);
        drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        #1;
        n_cmp++; if (o_if_pred_taken !== 1'b1) begin n_bad++; $display("FAIL beq_pred_after got %b want 1", o_if_pred_taken); end
        n_cmp++; if (o_br_count !== brc_m) begin n_bad++; $display("FAIL beq_br_count got %0d want %0d", o_br_count, brc_m); end
        n_cmp++; if (o_mispred_count !== mis_m) begin n_bad++; $display("FAIL beq_mis_count got %0d want %0d", o_mispred_count, mis_m); end
    endtask

    task automatic test_signed_unsigned();
        logic [31:0] brc0, mis0;
        logic [2:0]  f3s [2];
        brc0 = o_br_count;
        mis0 = o_mispred_count;
        f3s[0] = 3'd4;
        f3s[1] = 3'd6;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            drive(1, 1, f3s[k], 32'h200 + 32'(4 * k), 32'h400, 1, 1, 0);
            #1;
            n_cmp++; if (o_ex_br_un !== (k == 0)) begin n_bad++; $display("FAIL blt_br_un[%0d] got %b want %b", k, o_ex_br_un, k == 0); end
            n_cmp++; if (o_ex_taken !== 1'b1) begin n_bad++; $display("FAIL blt_taken[%0d] got %b want 1", k, o_ex_taken); end
            n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL blt_flush[%0d] got %b want 0", k, o_flush); end
            @(posedge i_clk);
            model_clock(1, 32'h200 + 32'(4 * k), 1, 0);
        end
        #1;
        n_cmp++; if (o_br_count !== brc0 + 32'd2) begin n_bad++; $display("FAIL blt_br_count got %0d want %0d", o_br_count, brc0 + 32'd2); end
        n_cmp++; if (o_mispred_count !== mis0) begin n_bad++; $display("FAIL blt_mis_count got %0d want %0d", o_mispred_count, mis0); end
    endtask

    task automatic test_wrap();
        @(negedge i_clk);
        drive(1, 1, 3'd5, 32'hFFFF_FFFC, 32'h1234, 1, 1, 0);
        #1;
        n_cmp++; if (o_ex_taken !== 1'b0) begin n_bad++; $display("FAIL bge_taken got %b want 0", o_ex_taken); end
        n_cmp++; if (o_flush !== 1'b1) begin n_bad++; $display("FAIL bge_flush got %b want 1", o_flush); end
        n_cmp++; if (o_redirect_pc !== 32'h0) begin n_bad++; $display("FAIL bge_redirect got %h want 00000000", o_redirect_pc); end
        @(posedge i_clk);
        model_clock(1, 32'hFFFF_FFFC, 0, 1);
        #1;
        n_cmp++; if (o_mispred_count !== mis_m) begin n_bad++; $display("FAIL bge_mis_count got %0d want %0d", o_mispred_count, mis_m); end
    endtask

    // Taken x4 then not-taken x2 on one entry, IF reading the same index each cycle.
    task automatic test_saturation_same_index();
        logic [31:0] pc;
        logic        tk;
        pc = 32'h3A0;
        for (int k = 0; k < 6; k++) begin
            tk = (k < 4);
            @(negedge i_clk);
            i_if_pc = pc;
            drive(1, 1, 3'd0, pc, 32'h40, tk, 1'b0, tk);
            #1;
            n_cmp++; if (o_if_pred_taken !== pred_of(pc)) begin n_bad++; $display("FAIL sat_pred[%0d] got %b want %b", k, o_if_pred_taken, pred_of(pc)); end
            n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL sat_flush[%0d] got %b want 0", k, o_flush); end
            @(posedge i_clk);
            model_clock(1, pc, tk, 0);
            #1;
            n_cmp++; if (o_if_pred_taken !== pred_of(pc)) begin n_bad++; $display("FAIL sat_pred_post[%0d] got %b want %b", k, o_if_pred_taken, pred_of(pc)); end
        end
    endtask

    task automatic test_illegal_and_reset();
        logic [31:0] brc0, mis0;
        logic        pred0;
        brc0 = o_br_count;
        mis0 = o_mispred_count;
        @(negedge i_clk);
        i_if_pc = 32'h100;
        pred0 = pred_of(32'h100);
        drive(1, 1, 3'd2, 32'h100, 32'h80, 0, 1, 1);
        #1;
        n_cmp++; if (o_ex_taken !== 1'b0) begin n_bad++; $display("FAIL ill_taken got %b want 0", o_ex_taken); end
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL ill_flush got %b want 0", o_flush); end
        n_cmp++; if (o_redirect_pc !== 32'h104) begin n_bad++; $display("FAIL ill_redirect got %h want 00000104", o_redirect_pc); end
        @(posedge i_clk);
        #1;
        n_cmp++; if (o_br_count !== brc0) begin n_bad++; $display("FAIL ill_br_count got %0d want %0d", o_br_count, brc0); end
        n_cmp++; if (o_mispred_count !== mis0) begin n_bad++; $display("FAIL ill_mis_count got %0d want %0d", o_mispred_count, mis0); end
        n_cmp++; if (o_if_pred_taken !== pred0) begin n_bad++; $display("FAIL ill_bht got %b want %b", o_if_pred_taken, pred0); end
        i_ex_valid = 1'b0;
        #1;
        i_reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (o_br_count !== 32'd0) begin n_bad++; $display("FAIL arst_br_count got %0d want 0", o_br_count); end
        n_cmp++; if (o_mispred_count !== 32'd0) begin n_bad++; $display("FAIL arst_mis_count got %0d want 0", o_mispred_count); end
        n_cmp++; if (o_if_pred_taken !== 1'b0) begin n_bad++; $display("FAIL arst_pred got %b want 0", o_if_pred_taken); end
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // The bench plays the comparator, using the mode select the DUT asks for.
    task automatic test_random();
        logic [31:0] a, b, pc, ifpc, tgt;
        logic [2:0]  f3;
        logic        v, br, pred, bv, tk, fl, pexp;
        logic [31:0] rexp;
        for (int n = 0; n < 400; n++) begin
            @(negedge i_clk);
            a    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc   = $urandom;
            ifpc = ($urandom_range(0, 2) == 0) ? pc : $urandom;
            tgt  = $urandom;
            f3   = 3'($urandom_range(0, 7));
            v    = ($urandom_range(0, 7) != 0);
            br   = ($urandom_range(0, 7) != 0);
            pred = 1'($urandom_range(0, 1));
            i_if_pc = ifpc;
            drive(v, br, f3, pc, tgt, pred, 0, 0);
            #1;
            i_ex_br_less  = o_ex_br_un ? ($signed(a) < $signed(b)) : (a < b);
            i_ex_br_equal = (a == b);
            #1;
            bv   = v & br & legal_of(f3);
            tk   = bv & isa_taken(f3, a, b);
            fl   = bv & (tk != pred);
            rexp = (fl & tk) ? tgt : pc + 32'd4;
            pexp = pred_of(ifpc);
            n_cmp++; if (o_ex_taken !== tk) begin n_bad++; $display("FAIL rnd_taken[%0d] f3=%0d a=%h b=%h got %b want %b", n, f3, a, b, o_ex_taken, tk); end
            n_cmp++; if (o_flush !== fl) begin n_bad++; $display("FAIL rnd_flush[%0d] got %b want %b", n, o_flush, fl); end
            n_cmp++; if (o_redirect_pc !== rexp) begin n_bad++; $display("FAIL rnd_redirect[%0d] got %h want %h", n, o_redirect_pc, rexp); end
            n_cmp++; if (o_if_pred_taken !== pexp) begin n_bad++; $display("FAIL rnd_pred[%0d] pc=%h got %b want %b", n, ifpc, o_if_pred_taken, pexp); end
            @(posedge i_clk);
            model_clock(bv, pc, tk, fl);
            #1;
            n_cmp++; if (o_br_count !== brc_m) begin n_bad++; $display("FAIL rnd_br_count[%0d] got %0d want %0d", n, o_br_count, brc_m); end
            n_cmp++; if (o_mispred_count !== mis_m) begin n_bad++; $display("FAIL rnd_mis_count[%0d] got %0d want %0d", n, o_mispred_count, mis_m); end
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_wrap();
        test_saturation_same_index();
        test_illegal_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
